// File: rtl/cpu_mon_pkg.sv
// Shared widths, default CPU state encodings and pointer/count sizing for the
// CPU trace monitor and its trace FIFO.
package cpu_mon_pkg;

  localparam int INSTR_W          = 32;
  localparam int DEF_FETCH_STATE  = 0;
  localparam int DEF_DECODE_STATE = 1;

  function automatic int entry_w(input int addr_w);
    return addr_w + INSTR_W;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer with registered read port. WRAP!=0 overwrites the oldest
// entry when full; WRAP==0 discards the incoming entry. Both cases set overflow.
module trace_fifo
  import cpu_mon_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      full,
  output logic                      overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic do_pop, wr_new, wr_pass, wr_ovw, wr_drop, do_write, rd_adv;

  // A push into a full buffer that coincides with a pop is a plain pass-through.
  always_comb begin
    full     = (count == DEPTH_C);
    do_pop   = rd_en && (count != '0);
    wr_new   = wr_en && !full;
    wr_pass  = wr_en && full && do_pop;
    wr_ovw   = wr_en && full && !do_pop && (WRAP != 0);
    wr_drop  = wr_en && full && !do_pop && (WRAP == 0);
    do_write = wr_new || wr_pass || wr_ovw;
    rd_adv   = do_pop || wr_ovw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) rd_data <= mem[rd_ptr];
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !rd_adv) count <= count + 1'b1;
      else if (rd_adv && !do_write) count <= count - 1'b1;
      if (wr_ovw || wr_drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Retirement tracer, saturating counters and hang watchdog for the multicycle CPU.
// Optional store counter enabled by defining CPU_MON_STORE_CNT_EN.
module cpu_trace_monitor
  import cpu_mon_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STATE_W      = 4,
  parameter int FETCH_STATE  = DEF_FETCH_STATE,
  parameter int DECODE_STATE = DEF_DECODE_STATE,
  parameter int DEPTH        = 16,
  parameter int WRAP         = 1,
  parameter int WDOG_CYCLES  = 64,
  parameter int CNT_W        = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [STATE_W-1:0]         state,
  input  logic [ADDR_W-1:0]          pc,
  input  logic [INSTR_W-1:0]         ir,
  input  logic                       mem_write,
  input  logic                       trace_rd_en,
  output logic [entry_w(ADDR_W)-1:0] trace_rd_data,
  output logic                       trace_rd_valid,
  output logic [count_w(DEPTH)-1:0]  trace_count,
  output logic                       trace_full,
  output logic                       trace_overflow,
  output logic [CNT_W-1:0]           instr_count,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           store_count,
  output logic                       hang
);

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [STATE_W-1:0] FETCH_S    = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] DECODE_S   = STATE_W'(DECODE_STATE);
  localparam logic [WD_W-1:0]    WDOG_LIMIT = WD_W'(WDOG_CYCLES);
  localparam logic [WD_W-1:0]    WDOG_PRE   = WD_W'(WDOG_CYCLES - 1);

  logic [STATE_W-1:0] prev_state;
  logic               first_fetch;
  logic               decode_pending;
  logic               have_instr;
  logic [ADDR_W-1:0]  fpc;
  logic [INSTR_W-1:0] fir;
  logic [WD_W-1:0]    wdog;
  logic in_fetch, fetch_entry, pc_latch, ir_latch, retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The very first fetch after reset/clear has no state edge, so first_fetch lets it capture pc.
  always_comb begin
    in_fetch    = enable && (state == FETCH_S);
    fetch_entry = in_fetch && (prev_state != FETCH_S);
    pc_latch    = in_fetch && ((prev_state != FETCH_S) || first_fetch);
    ir_latch    = enable && (state == DECODE_S) && decode_pending;
    retire      = fetch_entry && have_instr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_state     <= FETCH_S;
      first_fetch    <= 1'b1;
      decode_pending <= 1'b0;
      have_instr     <= 1'b0;
      wdog           <= '0;
      hang           <= 1'b0;
      instr_count    <= '0;
      cycle_count    <= '0;
    end else if (clear) begin
      if (enable) prev_state <= state;
      first_fetch    <= 1'b1;
      decode_pending <= 1'b0;
      have_instr     <= 1'b0;
      wdog           <= '0;
      hang           <= 1'b0;
      instr_count    <= '0;
      cycle_count    <= '0;
    end else if (enable) begin
      prev_state  <= state;
      cycle_count <= sat_inc(cycle_count);
      if (in_fetch) first_fetch <= 1'b0;
      if (pc_latch) decode_pending <= 1'b1;
      else if (ir_latch) decode_pending <= 1'b0;
      if (retire) begin
        have_instr  <= 1'b0;
        instr_count <= sat_inc(instr_count);
        wdog        <= '0;
      end else begin
        if (ir_latch) have_instr <= 1'b1;
        if (wdog != WDOG_LIMIT) wdog <= wdog + 1'b1;
        if (wdog == WDOG_PRE) hang <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pc_latch) fpc <= pc;
    if (ir_latch) fir <= ir;
  end

`ifdef CPU_MON_STORE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) store_count <= '0;
    else if (clear) store_count <= '0;
    else if (enable && mem_write) store_count <= sat_inc(store_count);
  end
`else
  logic unused_mem_write;
  assign unused_mem_write = mem_write;
  assign store_count      = '0;
`endif

  trace_fifo #(
    .DATA_W (entry_w(ADDR_W)),
    .DEPTH  (DEPTH),
    .WRAP   (WRAP)
  ) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (retire),
    .wr_data  ({fpc, fir}),
    .rd_en    (trace_rd_en),
    .rd_data  (trace_rd_data),
    .rd_valid (trace_rd_valid),
    .count    (trace_count),
    .full     (trace_full),
    .overflow (trace_overflow)
  );

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Scoreboard bench: a WRAP=1 and a WRAP=0 monitor share one CPU stimulus stream;
// popped entries are checked against per-instance expectation queues.
module tb_cpu_trace_monitor;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  state = 4'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] ir = 32'd0;
  logic        mem_write = 1'b0;
  logic        trace_rd_en = 1'b0;

  logic [63:0]   rd_data_w, rd_data_d;
  logic          rd_valid_w, rd_valid_d;
  logic [CW-1:0] tcount_w, tcount_d;
  logic          full_w, full_d, ovf_w, ovf_d, hang_w, hang_d;
  logic [31:0]   instr_w, instr_d, cycle_w, cycle_d, store_w, store_d;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_w[$];
  logic [63:0] exp_d[$];

  always #5 clk = ~clk;

  cpu_trace_monitor #(.DEPTH(DEPTH), .WRAP(1), .WDOG_CYCLES(64)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .state(state),
    .pc(pc), .ir(ir), .mem_write(mem_write), .trace_rd_en(trace_rd_en),
    .trace_rd_data(rd_data_w), .trace_rd_valid(rd_valid_w), .trace_count(tcount_w),
    .trace_full(full_w), .trace_overflow(ovf_w), .instr_count(instr_w),
    .cycle_count(cycle_w), .store_count(store_w), .hang(hang_w)
  );

  cpu_trace_monitor #(.DEPTH(DEPTH), .WRAP(0), .WDOG_CYCLES(64)) dut_d (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .state(state),
    .pc(pc), .ir(ir), .mem_write(mem_write), .trace_rd_en(trace_rd_en),
    .trace_rd_data(rd_data_d), .trace_rd_valid(rd_valid_d), .trace_count(tcount_d),
    .trace_full(full_d), .trace_overflow(ovf_d), .instr_count(instr_d),
    .cycle_count(cycle_d), .store_count(store_d), .hang(hang_d)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every read-valid pulse consumes one expected entry.
  always @(negedge clk) begin
    if (rd_valid_w) begin
      if (exp_w.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_w unexpected actual=0x%0h required=none", rd_data_w);
      end else check("pop_w", rd_data_w, exp_w.pop_front());
    end
    if (rd_valid_d) begin
      if (exp_d.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_d unexpected actual=0x%0h required=none", rd_data_d);
      end else check("pop_d", rd_data_d, exp_d.pop_front());
    end
  end

  task automatic step(input logic [3:0] st, input logic [31:0] p, input logic [31:0] i,
                      input logic rd, input logic mw);
    state = st;
    pc = p;
    ir = i;
    trace_rd_en = rd;
    mem_write = mw;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ent(input int k);
    return {32'(k * 4), 32'h1000_0000 + 32'(k)};
  endfunction

  task automatic instr(input int k, input logic rd_on_fetch);
    step(4'd0, 32'(k * 4), 32'h0, rd_on_fetch, 1'b0);
    step(4'd1, 32'(k * 4 + 4), 32'h1000_0000 + 32'(k), 1'b0, 1'b0);
    step(4'd2, 32'(k * 4 + 4), 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(4'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count_w"}, 64'(tcount_w), 0);
    check({tag, "_count_d"}, 64'(tcount_d), 0);
    check({tag, "_full_w"}, 64'(full_w), 0);
    check({tag, "_ovf_w"}, 64'(ovf_w), 0);
    check({tag, "_instr_w"}, 64'(instr_w), 0);
    check({tag, "_cycle_w"}, 64'(cycle_w), 0);
    check({tag, "_store_w"}, 64'(store_w), 0);
    check({tag, "_hang_w"}, 64'(hang_w), 0);
    check({tag, "_hang_d"}, 64'(hang_d), 0);
    check({tag, "_valid_w"}, 64'(rd_valid_w), 0);
    check({tag, "_data_w"}, rd_data_w, 0);
    check({tag, "_data_d"}, rd_data_d, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    enable = 1'b1;

    // Test 1: two retired instructions read back in order
    exp_w.push_back({32'h0, 32'h2001_0005});
    exp_d.push_back({32'h0, 32'h2001_0005});
    exp_w.push_back({32'h4, 32'h2002_0007});
    exp_d.push_back({32'h4, 32'h2002_0007});
    step(4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(4'd1, 32'h4, 32'h2001_0005, 1'b0, 1'b0);
    step(4'd2, 32'h4, 32'h0, 1'b0, 1'b0);
    step(4'd0, 32'h4, 32'h0, 1'b0, 1'b0);
    step(4'd1, 32'h8, 32'h2002_0007, 1'b0, 1'b0);
    step(4'd2, 32'h8, 32'h0, 1'b0, 1'b0);
    step(4'd0, 32'h8, 32'h0, 1'b0, 1'b0);
    check("t1_count_w", 64'(tcount_w), 2);
    check("t1_instr_w", 64'(instr_w), 2);
    check("t1_instr_d", 64'(instr_d), 2);
    check("t1_cycle_w", 64'(cycle_w), 7);
    step(4'd2, 32'h8, 32'h0, 1'b1, 1'b0);
    step(4'd2, 32'h8, 32'h0, 1'b1, 1'b0);
    step(4'd2, 32'h8, 32'h0, 1'b0, 1'b0);
    check("t1_drained_w", 64'(tcount_w), 0);

    // Test 5a: pop on an empty buffer is ignored
    step(4'd2, 32'h0, 32'h0, 1'b1, 1'b0);
    check("t5_empty_valid_w", 64'(rd_valid_w), 0);
    check("t5_empty_valid_d", 64'(rd_valid_d), 0);
    step(4'd2, 32'h0, 32'h0, 1'b1, 1'b0);
    check("t5_empty_count_w", 64'(tcount_w), 0);
    step(4'd2, 32'h0, 32'h0, 1'b0, 1'b0);

    // Test 5b: push and pop in one cycle while full
    do_clear();
    for (int k = 1; k <= 17; k++) instr(k, 1'b0);
    check("t5_full_w", 64'(full_w), 1);
    check("t5_full_d", 64'(full_d), 1);
    check("t5_ovf_pre_d", 64'(ovf_d), 0);
    exp_w.push_back(ent(1));
    exp_d.push_back(ent(1));
    instr(18, 1'b1);
    check("t5_pp_count_w", 64'(tcount_w), 16);
    check("t5_pp_count_d", 64'(tcount_d), 16);
    check("t5_pp_ovf_w", 64'(ovf_w), 0);
    check("t5_pp_ovf_d", 64'(ovf_d), 0);

    // Tests 2/3: 20 retires into a 16-deep buffer, both overflow policies
    do_clear();
    for (int k = 1; k <= 21; k++) instr(k, 1'b0);
    check("t2_count_w", 64'(tcount_w), 16);
    check("t3_count_d", 64'(tcount_d), 16);
    check("t2_ovf_w", 64'(ovf_w), 1);
    check("t3_ovf_d", 64'(ovf_d), 1);
    check("t2_instr_w", 64'(instr_w), 20);
    check("t3_instr_d", 64'(instr_d), 20);
    for (int k = 5; k <= 20; k++) exp_w.push_back(ent(k));
    for (int k = 1; k <= 16; k++) exp_d.push_back(ent(k));
    for (int i = 0; i < 16; i++) begin
      if (i == 8) enable = 1'b0;
      step(4'd2, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    step(4'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    enable = 1'b1;
    check("t2_drained_w", 64'(tcount_w), 0);
    check("t3_drained_d", 64'(tcount_d), 0);

    // Test 4: watchdog
    do_clear();
    instr(1, 1'b0);
    instr(2, 1'b0);
    repeat (61) step(4'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t4_hang_63_w", 64'(hang_w), 0);
    check("t4_hang_63_d", 64'(hang_d), 0);
    step(4'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t4_hang_64_w", 64'(hang_w), 1);
    check("t4_hang_64_d", 64'(hang_d), 1);
    instr(3, 1'b0);
    check("t4_hang_sticky_w", 64'(hang_w), 1);
    check("t4_instr_w", 64'(instr_w), 2);
    do_clear();
    check("t4_hang_clr_w", 64'(hang_w), 0);
    check("t4_hang_clr_d", 64'(hang_d), 0);

    // Test 6: reset pulsed mid-instruction
    instr(1, 1'b0);
    instr(2, 1'b0);
    exp_w.push_back(ent(1));
    exp_d.push_back(ent(1));
    step(4'd2, 32'h0, 32'h0, 1'b1, 1'b0);
    step(4'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    step(4'd0, 32'd12, 32'h0, 1'b0, 1'b0);
    step(4'd1, 32'd16, 32'h1000_0003, 1'b0, 1'b0);
    check("t6_pre_count_w", 64'(tcount_w), 1);
    reset = 1'b0;
    #2;
    check_zero("t6_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) step(4'd2, 32'd16, 32'h0, 1'b0, 1'b1);
    step(4'd0, 32'd16, 32'h0, 1'b0, 1'b0);
    step(4'd1, 32'd20, 32'h1000_0004, 1'b0, 1'b0);
    step(4'd2, 32'd20, 32'h0, 1'b0, 1'b0);
    check("t6_count_w", 64'(tcount_w), 0);
    check("t6_count_d", 64'(tcount_d), 0);
    check("t6_instr_w", 64'(instr_w), 0);
    check("t6_cycle_w", 64'(cycle_w), 6);
`ifdef CPU_MON_STORE_CNT_EN
    check("t6_store_w", 64'(store_w), 3);
    check("t6_store_d", 64'(store_d), 3);
`else
    check("t6_store_w", 64'(store_w), 0);
    check("t6_store_d", 64'(store_d), 0);
`endif

    step(4'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    check("sb_left_w", 64'(exp_w.size()), 0);
    check("sb_left_d", 64'(exp_d.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
